// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit port: FSM state encoding,
// default bit timing, UART line levels and the parity helper.
// The optional parity bit is controlled by the SERIAL_TX_PARITY_EN macro.
package serial_pkg;

  // Transmit FSM states. PARITY is only ever entered when the parity build
  // option is enabled; the encoding is fixed so debug tools see stable codes.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // 50 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Number of payload bits per frame.
  localparam int DATA_BITS = 8;

  // Line levels: the UART idles (and stops) high, the start bit is low.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Even parity bit for a byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Push is ignored while full and pop is ignored while empty, so the caller
// may present raw requests. Head data is shown combinationally on o_data.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [7:0]         i_data,
  input  logic               i_pop,
  output logic [7:0]         o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [FIFO_AW:0]   o_count
);

  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Qualified requests: a full FIFO never overwrites, an empty FIFO never underflows.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_port.sv
// Serial transmit port: accepts bytes from the processor's serial write
// interface, buffers them in serial_tx_fifo and sends them as UART frames
// (start, 8 data bits LSB first, optional even parity, stop).
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit.
//
// Handshake: a byte is accepted on every clock where wren_in and ready_out
// are both high. ready_out depends only on the registered FIFO count, so it
// never combinationally follows wren_in. A write while ready_out is low is
// dropped and latches overflow_out until reset.
module serial_tx_port
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         wr_data_in,
  input  logic               wren_in,
  output logic               ready_out,
  output logic               txd_out,
  output logic               busy_out,
  output logic [FIFO_AW:0]   fifo_count_out,
  output logic               overflow_out,
  output logic [2:0]         dbg_state_out
);

  localparam int                CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [CNT_W-1:0]  r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_next;
  logic              r_txd;
  logic              w_txd_next;
  logic              r_overflow;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_parity;
`endif

  logic              w_baud_end;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_fifo_data;
  logic [FIFO_AW:0]  w_count;

  serial_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (wr_data_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A bit period is over on the last count of the baud counter.
  assign w_baud_end = (r_baud == BAUD_LAST);

  // Accept a byte only while there is room.
  assign w_push = wren_in && !w_full;

  // Bytes leave the FIFO only when a frame starts: from IDLE, or straight
  // out of the last STOP cycle so consecutive frames have no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end));

  assign ready_out      = !w_full;
  assign fifo_count_out = w_count;
  assign busy_out       = (r_state != ST_IDLE) || !w_empty;
  assign overflow_out   = r_overflow;
  assign txd_out        = r_txd;
  assign dbg_state_out  = r_state;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic: every timed state lasts one full bit period.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_end && (r_bit_idx == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_end) begin
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_end) begin
          w_state_next = w_empty ? ST_IDLE : ST_START;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: line level for the state being entered, so the registered
  // txd changes on the same edge as the state.
  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = w_fifo_data;
    end else if ((r_state == ST_DATA) && w_baud_end) begin
      w_shift_next = r_shift >> 1;
    end

    w_txd_next = UART_IDLE_LEVEL;
    case (w_state_next)
      ST_START:  w_txd_next = UART_START_LEVEL;
      ST_DATA:   w_txd_next = w_shift_next[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: w_txd_next = r_parity;
`endif
      default:   w_txd_next = UART_IDLE_LEVEL;
    endcase
  end

  // Baud counter, bit index, shift register and registered line output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= UART_IDLE_LEVEL;
    end else begin
      // Counter restarts at every bit boundary and holds at zero when idle.
      if (w_baud_end || (r_state == ST_IDLE)) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BAUD_ONE;
      end

      if (w_pop) begin
        r_bit_idx <= '0;
      end else if ((r_state == ST_DATA) && w_baud_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from the whole byte at pop time, before shifting starts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= even_parity(w_fifo_data);
    end
  end
`endif

  // Sticky overflow: a write arrived while the FIFO was full.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (wren_in && w_full) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_tx_port.sv
// Bench for serial_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// The reference model keeps the pending bytes in a queue and, when a frame
// starts, expands the byte into the list of line levels it must produce,
// one entry per clock. A compare process checks every cycle; directed tests
// add literal expectations for the scenarios of interest.
module tb_serial_tx_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  wr_data_in = 8'h00;
  logic        wren_in = 1'b0;
  logic        ready_out;
  logic        txd_out;
  logic        busy_out;
  logic [AW:0] fifo_count_out;
  logic        overflow_out;
  logic [2:0]  dbg_state_out;

  serial_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_data_in     (wr_data_in),
    .wren_in        (wren_in),
    .ready_out      (ready_out),
    .txd_out        (txd_out),
    .busy_out       (busy_out),
    .fifo_count_out (fifo_count_out),
    .overflow_out   (overflow_out),
    .dbg_state_out  (dbg_state_out)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];     // bytes waiting in the FIFO
  logic       m_wave[$];    // line levels still to be driven by the current frame
  logic       m_ovf = 1'b0;
  int         m_pre;
  bit         m_do_push;
  logic [7:0] m_b;

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_wave.delete();
      m_ovf = 1'b0;
    end else begin
      m_pre = exp_q.size();
      m_do_push = 1'b0;
      if (m_wave.size() > 0) void'(m_wave.pop_front());
      if (wren_in) begin
        if (m_pre < DEPTH) m_do_push = 1'b1;
        else m_ovf = 1'b1;
      end
      // A new frame starts when the line is free and a byte was waiting.
      if (m_wave.size() == 0 && m_pre > 0) begin
        m_b = exp_q.pop_front();
        for (int c = 0; c < CPB; c++) m_wave.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int c = 0; c < CPB; c++) m_wave.push_back(m_b[i]);
`ifdef SERIAL_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) m_wave.push_back(^m_b);
`endif
        for (int c = 0; c < CPB; c++) m_wave.push_back(1'b1);
      end
      if (m_do_push) exp_q.push_back(wr_data_in);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("txd",   32'(txd_out), 32'((m_wave.size() > 0) ? m_wave[0] : 1'b1));
      check("count", 32'(fifo_count_out), 32'(exp_q.size()));
      check("ready", 32'(ready_out), 32'(exp_q.size() != DEPTH));
      check("busy",  32'(busy_out), 32'(m_wave.size() > 0 || exp_q.size() > 0));
      check("ovf",   32'(overflow_out), 32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left at a negedge.
  task automatic write_byte(input logic [7:0] b);
    wr_data_in = b;
    wren_in    = 1'b1;
    @(negedge clock);
    wren_in    = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_wave.size() != 0) && i < 5000) begin
      @(negedge clock);
      i++;
    end
    if (i >= 5000) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_idle: model still busy after %0d cycles, required idle", i);
    end
    @(negedge clock);
  endtask

  // Single byte from idle; bits holds the frame LSB first (bit 0 = start).
  task automatic single_frame(input logic [7:0] b, input logic [10:0] bits);
    write_byte(b);
    check("frame_pre_txd", 32'(txd_out), 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clock);
      check("frame_bit", 32'(txd_out), 32'(bits[k / CPB]));
    end
    check("frame_busy_last", 32'(busy_out), 32'd1);
    @(negedge clock);
    check("frame_busy_done", 32'(busy_out), 32'd0);
  endtask

  // ---------------- burst peak tracking ----------------
  bit track = 1'b0;
  int peak  = 0;
  always @(negedge clock) begin
    if (track && int'(fifo_count_out) > peak) peak = int'(fifo_count_out);
  end

  logic [10:0] bits_v;
  int          dens;
  int          guard;

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_txd",   32'(txd_out), 32'd1);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_busy",  32'(busy_out), 32'd0);
    check("rst_count", 32'(fifo_count_out), 32'd0);
    check("rst_ovf",   32'(overflow_out), 32'd0);
    check("rst_state", 32'(dbg_state_out), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop.
`ifdef SERIAL_TX_PARITY_EN
    bits_v = 11'b1_0_10100101_0;
`else
    bits_v = 11'b0_1_10100101_0;
`endif
    single_frame(8'hA5, bits_v);
    repeat (3) @(negedge clock);

    // Three back-to-back writes; model enforces zero-gap frames.
    peak  = 0;
    track = 1'b1;
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    wait_idle();
    track = 1'b0;
    check("burst_peak_2or3", 32'(peak == 2 || peak == 3), 32'd1);

    // Fill while a frame is on the line, then overflow with the 9th write.
    write_byte(8'h55);
    @(negedge clock);
    check("fill_first_popped", 32'(fifo_count_out), 32'd0);
    for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
    check("fill_ready_low", 32'(ready_out), 32'd0);
    check("fill_count8",    32'(fifo_count_out), 32'd8);
    check("fill_no_ovf",    32'(overflow_out), 32'd0);
    write_byte(8'hEE);
    check("ovf_set",        32'(overflow_out), 32'd1);
    check("ovf_count8",     32'(fifo_count_out), 32'd8);
    guard = 0;
    while (fifo_count_out == 4'd8 && guard < 4 * FRAME) begin
      @(negedge clock);
      guard++;
    end
    check("pop_timeout", 32'(guard < 4 * FRAME), 32'd1);
    check("pop_count7",  32'(fifo_count_out), 32'd7);
    check("pop_ready",   32'(ready_out), 32'd1);
    check("ovf_sticky",  32'(overflow_out), 32'd1);
    wait_idle();

    // Reset in the middle of the data bits of 0xFF with two bytes queued.
    write_byte(8'hFF);
    write_byte(8'h81);
    write_byte(8'h42);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_txd",   32'(txd_out), 32'd1);
    check("midrst_count", 32'(fifo_count_out), 32'd0);
    check("midrst_ovf",   32'(overflow_out), 32'd0);
    repeat (3 * FRAME) @(negedge clock);
    check("midrst_no_frames", 32'(busy_out), 32'd0);

    // Push coincident with the pop at the end of a STOP bit.
    write_byte(8'h3C);
    write_byte(8'hC3);
    repeat (FRAME - 1) @(negedge clock);
    check("copush_count_before", 32'(fifo_count_out), 32'd1);
    write_byte(8'h96);
    check("copush_count_after", 32'(fifo_count_out), 32'd1);
    check("copush_start", 32'(txd_out), 32'd0);
    wait_idle();

    // 0x07: parity bit is 1 when enabled.
`ifdef SERIAL_TX_PARITY_EN
    bits_v = 11'b1_1_00000111_0;
`else
    bits_v = 11'b0_1_00000111_0;
`endif
    single_frame(8'h07, bits_v);

    // Randomized traffic in phases of varying write density, rare resets.
    for (int ph = 0; ph < 12; ph++) begin
      dens = (ph % 4 == 0) ? 2 : (ph % 4 == 1) ? 10 : (ph % 4 == 2) ? 40 : 75;
      for (int c = 0; c < 250; c++) begin
        wr_data_in = 8'($urandom_range(255));
        wren_in    = ($urandom_range(99) < dens);
        reset      = ($urandom_range(599) == 0);
        @(negedge clock);
      end
    end
    wren_in = 1'b0;
    reset   = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
